// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the serial frame receiver: state encoding
// and the helper that sizes the data-bit counter.
package serial_frame_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STOP  = 2'd2,
        BREAK = 2'd3
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 16;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_frame_receiver_shift.sv
// LSB-first shift-in register holding the partially received word;
// each enabled cycle pushes serial_in into the MSB.
module shift_in_register #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            Q <= '0;
        end else if (shift_en) begin
            Q <= {serial_in, Q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_frame_receiver.sv
// Strobe-driven serial frame receiver: start bit, WIDTH data bits
// LSB-first, one stop bit; good frames load D, bad stop bits flag an error.
module serial_frame_receiver
    import serial_frame_receiver_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] D,
    output logic             load,
    output logic             busy,
    output logic             frame_err
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [WIDTH-1:0] d_n;
    logic             load_n;
    logic             err_n;
    logic             shift_en;
    logic [WIDTH-1:0] shreg;

    shift_in_register #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .serial_in(serial_in),
        .Q        (shreg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            D         <= '0;
            load      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            D         <= d_n;
            load      <= load_n;
            frame_err <= err_n;
        end
    end

    // Without a strobe everything holds; only the pulses fall back to 0.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        d_n      = D;
        load_n   = 1'b0;
        err_n    = 1'b0;
        shift_en = 1'b0;
        if (bit_en) begin
            unique case (state)
                IDLE: begin
                    if (!serial_in) begin
                        state_n = DATA;
                        cnt_n   = '0;
                    end
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (cnt == LAST) begin
                        cnt_n   = '0;
                        state_n = STOP;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (serial_in) begin
                        d_n     = shreg;
                        load_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = BREAK;
                    end
                end
                BREAK: begin
                    // A held-low line is a break, never a start bit.
                    if (serial_in) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver (WIDTH=3): stimulus queues
// expected load/error events, a negedge monitor pops and checks them.
module tb_serial_frame_receiver;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         bit_en;
    logic         serial_in;
    logic [W-1:0] D;
    logic         load;
    logic         busy;
    logic         frame_err;

    typedef struct {
        bit           is_load;
        logic [W-1:0] data;
        int           cyc;
    } ev_t;

    ev_t          sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    logic [W-1:0] model_d;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_frame_receiver #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bit_en   (bit_en),
        .serial_in(serial_in),
        .D        (D),
        .load     (load),
        .busy     (busy),
        .frame_err(frame_err)
    );

    task automatic step(input logic r, input logic e, input logic s);
        reset     = r;
        bit_en    = e;
        serial_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic gap(input int gmax);
        int n;
        n = (gmax > 0) ? $urandom_range(gmax, 0) : 0;
        repeat (n) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic frame(input logic [W-1:0] data, input logic stop,
                         input int gmax);
        gap(gmax);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < W; i++) begin
            gap(gmax);
            step(1'b0, 1'b1, data[i]);
        end
        gap(gmax);
        step(1'b0, 1'b1, stop);
        if (stop) begin
            model_d = data;
            sb.push_back('{is_load: 1'b1, data: data, cyc: cyc});
        end else begin
            sb.push_back('{is_load: 1'b0, data: model_d, cyc: cyc});
        end
    endtask

    always @(negedge clk) begin
        if (load && frame_err) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pulse_overlap: load=1 frame_err=1 at cyc %0d", cyc);
        end else if (load || frame_err) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: load=%0b err=%0b D=%0h cyc %0d",
                         load, frame_err, D, cyc);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (load !== e.is_load || D !== e.data || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL event: got load=%0b D=%0h cyc=%0d want load=%0b D=%0h cyc=%0d",
                             load, D, cyc, e.is_load, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        bit_en    = 1'b0;
        serial_in = 1'b1;
        model_d   = '0;
        repeat (2) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("rst_D", int'(D), 0);
        check("rst_load", int'(load), 0);
        check("rst_err", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);

        // good frame 101
        frame(3'b101, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1);
        check("good_busy", int'(busy), 0);
        check("good_D", int'(D), 5);

        // bad stop bit, then break handling
        frame(3'b111, 1'b0, 0);
        check("brk_busy0", int'(busy), 1);
        step(1'b0, 1'b0, 1'b1);
        check("brk_D", int'(D), 5);
        step(1'b0, 1'b1, 1'b0);
        check("brk_hold", int'(busy), 1);
        step(1'b0, 1'b1, 1'b1);
        check("brk_exit", int'(busy), 0);

        // back-to-back, bit_en every cycle
        frame(3'b011, 1'b1, 0);
        frame(3'b110, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1);
        check("b2b_D", int'(D), 6);

        // reset mid-frame after second data bit
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        model_d = '0;
        check("mid_rst_D", int'(D), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_load", int'(load), 0);
        step(1'b0, 1'b0, 1'b1);
        frame(3'b100, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1);
        check("post_rst_D", int'(D), 4);

        // random strobe gaps
        frame(3'b010, 1'b1, 7);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        check("gap_D", int'(D), 2);

        // reset beats a start bit in the same cycle
        step(1'b1, 1'b1, 1'b0);
        model_d = '0;
        check("rst_start_busy", int'(busy), 0);
        step(1'b0, 1'b0, 1'b1);
        check("rst_start_busy2", int'(busy), 0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("rst_start_idle", int'(busy), 0);
        check("rst_start_D", int'(D), 0);

        repeat (3) step(1'b0, 1'b0, 1'b1);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_frame_receiver.md
SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 Parameter WIDTH, default 3, data bits per frame; the legal range SHALL be 2..16.
REQ-002 clk  input  1  single clock; all state SHALL change on posedge clk only.
REQ-003 reset  input  1  reset SHALL be synchronous and active-high.
REQ-004 bit_en  input  1  bit-sample strobe; serial_in SHALL be sampled only in cycles with bit_en=1.
REQ-005 serial_in  input  1  serial line; idle level 1.
REQ-006 D  output  WIDTH  last correctly framed word, registered; feeds the downstream parallel register D input.
REQ-007 load  output  1  one-cycle pulse marking a new valid D; feeds the downstream load input.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 frame_err  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-010 The FSM SHALL have exactly four states: IDLE, DATA, STOP, BREAK.
REQ-011 IDLE: on bit_en=1 with serial_in=0 (start bit), the FSM SHALL go to DATA with the bit counter at 0; otherwise it stays in IDLE.
REQ-012 DATA: on each bit_en=1, the shift register SHALL take serial_in LSB-first, {serial_in, shreg[WIDTH-1:1]}, and the counter SHALL increment.
REQ-013 DATA: the strobe that samples bit WIDTH-1 SHALL move the FSM to STOP; the counter SHALL never exceed WIDTH-1 and SHALL return to 0.
REQ-014 STOP: on bit_en=1 with serial_in=1, D SHALL be loaded with shreg, load SHALL pulse high for exactly one cycle, and the FSM SHALL go to IDLE.
REQ-015 Latency: D and load SHALL both update on the clock edge that samples the stop strobe, so load and the new D are visible in the same following cycle.
REQ-016 STOP: on bit_en=1 with serial_in=0, frame_err SHALL pulse for one cycle, D SHALL be unchanged, load SHALL stay 0, and the FSM SHALL go to BREAK.
REQ-017 BREAK: the FSM SHALL stay in BREAK until a bit_en=1 with serial_in=1, then go to IDLE; a 0 in BREAK SHALL never be taken as a start bit.
REQ-018 Cycles with bit_en=0 SHALL change nothing except clearing the load and frame_err pulses.
REQ-019 D SHALL hold its value between good frames, including across errored frames.
REQ-020 load and frame_err SHALL never be high in the same cycle.
REQ-021 Back-to-back frames: a start bit on the first strobe after the stop strobe SHALL be accepted with no idle gap.
REQ-022 bit_en held high every cycle SHALL be legal, giving one bit per clock.

Reset
REQ-023 While reset=1 at a clock edge: FSM=IDLE, counter=0, shreg=0, D=0, load=0, frame_err=0, busy=0.
REQ-024 Reset SHALL take priority over bit_en in the same cycle.
REQ-025 Reset mid-frame SHALL discard the partial frame with no load pulse; after release, only a new start bit begins a frame.

Structure
REQ-026 The state encoding (2-bit localparams IDLE=0, DATA=1, STOP=2, BREAK=3) SHALL live in the shared lab package.
REQ-027 The counter width SHALL be $clog2(WIDTH) and SHALL be derived in the package or module, not hard-coded.
REQ-028 One sub-module, shift_in_register (WIDTH, clk, reset, shift_en, serial_in, Q), SHALL hold shreg; the FSM, counter and output registers SHALL stay in the top module.

Verification (WIDTH=3)
REQ-029 Reset, then strobes carrying 0,1,0,1,1 (start, data LSB-first, stop) -> D=3'b101 with load=1 for one cycle, busy low afterward.
REQ-030 Start, data 1,1,1, stop=0 -> frame_err one cycle, D keeps 3'b101, FSM in BREAK; a strobe with 0 stays in BREAK; a strobe with 1 -> IDLE.
REQ-031 bit_en=1 every cycle with two back-to-back frames carrying 3'b011 then 3'b110 -> two load pulses exactly 5 cycles apart, D=3'b011 then 3'b110.
REQ-032 Reset asserted after the second data bit -> no load, D=0, busy=0; the next full frame carrying 3'b100 loads normally.
REQ-033 bit_en gaps of 0-7 random idle cycles between strobes on frame 3'b010 -> same D and a single load pulse, issued on the stop strobe.
REQ-034 Reset and bit_en with serial_in=0 asserted in the same cycle -> FSM IDLE, start bit ignored.
